cnn_dma_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single DMA read engine among the CNN controller's fetch clients: layer-count, layer-header, filter and image-block loads. Each client posts an address and word count. The arbiter grants one client at a time, issues a one-cycle `dma_enable` with the latched request, and waits for `dma_op_done`. It then returns a one-cycle `ack` to the winning client. It sits between the CNN control FSM / conv / pool units and the DMA that fills the `dmaOut` block buffer.

---
 rtl/cnn_dma_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cnn_dma_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_dma_arbiter.sv
// cnn_dma_arbiter: round-robin arbiter and sequencer sharing the single DMA
// read engine among the CNN fetch clients (layer count, layer header, filter,
// image block). One client owns the DMA from grant until its ack pulse.
// Optional WAIT watchdog: define CNN_DMA_ARB_TIMEOUT_EN to enable it; in the
// default build WAIT has no limit and err is tied low.
module cnn_dma_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MEM_ADDR_SIZE  = 20,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*MEM_ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]         req_len,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               ack,
    output logic [NUM_REQ-1:0]               err,
    output logic                             dma_enable,
    output logic [MEM_ADDR_SIZE-1:0]         dma_address,
    output logic [LEN_W-1:0]                 dma_len,
    input  logic                             dma_op_done,
    output logic                             busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state, stateNext;
    logic [PTR_W-1:0]         rrPtr, rrPtrNext;
    logic [PTR_W-1:0]         owner, ownerNext;
    logic [NUM_REQ-1:0]       grantNext, ackNext;
    logic                     enableNext, busyNext;
    logic [MEM_ADDR_SIZE-1:0] addrNext;
    logic [LEN_W-1:0]         lenNext;

    logic                     pickValid;
    logic [PTR_W-1:0]         pickIdx;
    logic [PTR_W-1:0]         scanIdx;
    logic [MEM_ADDR_SIZE-1:0] pickAddr;
    logic [LEN_W-1:0]         pickLen;

`ifdef CNN_DMA_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]         waitCnt, waitCntNext;
    logic [NUM_REQ-1:0]       errNext;
`endif

    // Round-robin pick: first requester at or after rrPtr, wrapping at NUM_REQ,
    // plus a mux of that client's address and length.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        scanIdx   = '0;
        pickAddr  = '0;
        pickLen   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scanIdx = PTR_W'((int'(rrPtr) + i) % NUM_REQ);
            if (!pickValid && req[scanIdx]) begin
                pickValid = 1'b1;
                pickIdx   = scanIdx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickIdx == PTR_W'(i)) begin
                pickAddr = req_addr[i*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
                pickLen  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        stateNext  = state;
        rrPtrNext  = rrPtr;
        ownerNext  = owner;
        grantNext  = grant;
        ackNext    = '0;
        enableNext = 1'b0;
        addrNext   = dma_address;
        lenNext    = dma_len;
`ifdef CNN_DMA_ARB_TIMEOUT_EN
        errNext     = '0;
        waitCntNext = waitCnt;
`endif
        case (state)
            IDLE: begin
                if (pickValid) begin
                    ownerNext = pickIdx;
                    grantNext = NUM_REQ'(1) << pickIdx;
                    addrNext  = pickAddr;
                    lenNext   = pickLen;
                    // A zero-length fetch never touches the DMA.
                    if (pickLen != '0) begin
                        stateNext  = ISSUE;
                        enableNext = 1'b1;
                    end else begin
                        stateNext = RESP;
                        ackNext   = NUM_REQ'(1) << pickIdx;
                    end
                end
            end
            ISSUE: begin
                stateNext = WAIT;
`ifdef CNN_DMA_ARB_TIMEOUT_EN
                waitCntNext = '0;
`endif
            end
            WAIT: begin
                if (dma_op_done) begin
                    stateNext = RESP;
                    ackNext   = grant;
                end
`ifdef CNN_DMA_ARB_TIMEOUT_EN
                else if (waitCnt == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    stateNext = RESP;
                    ackNext   = grant;
                    errNext   = grant;
                end else begin
                    waitCntNext = waitCnt + 1'b1;
                end
`endif
            end
            RESP: begin
                stateNext = IDLE;
                grantNext = '0;
                rrPtrNext = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext != IDLE);
    end

    // State and output registers; reset aborts any transfer without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rrPtr       <= '0;
            owner       <= '0;
            grant       <= '0;
            ack         <= '0;
            dma_enable  <= 1'b0;
            dma_address <= '0;
            dma_len     <= '0;
            busy        <= 1'b0;
`ifdef CNN_DMA_ARB_TIMEOUT_EN
            err         <= '0;
            waitCnt     <= '0;
`endif
        end else begin
            state       <= stateNext;
            rrPtr       <= rrPtrNext;
            owner       <= ownerNext;
            grant       <= grantNext;
            ack         <= ackNext;
            dma_enable  <= enableNext;
            dma_address <= addrNext;
            dma_len     <= lenNext;
            busy        <= busyNext;
`ifdef CNN_DMA_ARB_TIMEOUT_EN
            err         <= errNext;
            waitCnt     <= waitCntNext;
`endif
        end
    end

`ifndef CNN_DMA_ARB_TIMEOUT_EN
    assign err = '0;
`endif

endmodule

// File: tb/tb_cnn_dma_arbiter.sv
// Self-checking bench for cnn_dma_arbiter: directed scenarios plus a
// randomized run against a round-robin reference model.
`timescale 1ns/1ps
module tb_cnn_dma_arbiter;
    localparam int N  = 4;
    localparam int AW = 20;
    localparam int LW = 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [AW-1:0]   addrArr [N];
    logic [LW-1:0]   lenArr  [N];
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    grant, ack, err;
    logic            dma_enable, dma_op_done, busy;
    logic [AW-1:0]   dma_address;
    logic [LW-1:0]   dma_len;

    int tests = 0;
    int fails = 0;
    int modelPtr = 0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = addrArr[g];
        assign req_len[g*LW +: LW]  = lenArr[g];
    end

    always #5 clk = ~clk;

    cnn_dma_arbiter #(
        .NUM_REQ(N), .MEM_ADDR_SIZE(AW), .LEN_W(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_len(req_len), .grant(grant), .ack(ack), .err(err),
        .dma_enable(dma_enable), .dma_address(dma_address), .dma_len(dma_len),
        .dma_op_done(dma_op_done), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration rule: first set request scanning up from ptr.
    function automatic int pickModel(logic [N-1:0] r, int ptr);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr + i) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic randomizeClients(bit allowZero);
        for (int i = 0; i < N; i++) begin
            addrArr[i] = AW'($urandom);
            if (allowZero && $urandom_range(3) == 0) lenArr[i] = '0;
            else lenArr[i] = LW'($urandom_range(1, 255));
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; dma_op_done = 1'b0;
        randomizeClients(0);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({grant, ack, err, dma_enable, dma_address, dma_len, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got g=%b a=%b e=%b en=%b addr=%h len=%h busy=%b required all 0",
                     grant, ack, err, dma_enable, dma_address, dma_len, busy);
        end
        reset = 1'b0; modelPtr = 0;
        tick;
        tests++;
        if ({busy, grant} !== '0) begin
            fails++; $display("FAIL reset_idle: busy=%b grant=%b required 0", busy, grant);
        end
    endtask

    task automatic test_single;
        addrArr[1] = 20'h00010; lenArr[1] = 8'd3; req = 4'b0010;
        tick;
        tests++;
        if ({dma_enable, grant, busy, ack, dma_address, dma_len} !== {1'b1, 4'b0010, 1'b1, 4'b0000, 20'h00010, 8'd3}) begin
            fails++;
            $display("FAIL single_strobe: en=%b g=%b busy=%b ack=%b addr=%h len=%0d required 1 0010 1 0000 00010 3",
                     dma_enable, grant, busy, ack, dma_address, dma_len);
        end
        tick;
        tests++;
        if ({dma_enable, ack} !== 5'b0) begin
            fails++; $display("FAIL single_wait: en=%b ack=%b required 0", dma_enable, ack);
        end
        tick;
        dma_op_done = 1'b1;
        tick;
        dma_op_done = 1'b0;
        tests++;
        if ({ack, grant} !== {4'b0010, 4'b0010}) begin
            fails++; $display("FAIL single_ack: ack=%b grant=%b required 0010 0010", ack, grant);
        end
        req = '0;
        tick;
        tests++;
        if ({ack, grant, busy} !== 9'b0) begin
            fails++; $display("FAIL single_release: ack=%b grant=%b busy=%b required 0", ack, grant, busy);
        end
        modelPtr = 2;
    endtask

    task automatic test_round_robin;
        int exp;
        time lastT;
        reset = 1'b1; tick; reset = 1'b0; modelPtr = 0;
        randomizeClients(0);
        req = '1;
        lastT = 0;
        tick;
        for (int n = 0; n < 5; n++) begin
            exp = pickModel(req, modelPtr);
            tests++;
            if ({dma_enable, grant, dma_address, dma_len} !== {1'b1, N'(1 << exp), addrArr[exp], lenArr[exp]}) begin
                fails++;
                $display("FAIL rr_grant[%0d]: en=%b g=%b addr=%h len=%h required 1 %b %h %h", n,
                         dma_enable, grant, dma_address, dma_len, N'(1 << exp), addrArr[exp], lenArr[exp]);
            end
            if (n > 0) begin
                tests++;
                if ($time - lastT != 40) begin
                    fails++; $display("FAIL rr_period[%0d]: got %0t required 40ns", n, $time - lastT);
                end
            end
            lastT = $time;
            tick;
            dma_op_done = 1'b1;
            tick;
            dma_op_done = 1'b0;
            tests++;
            if (ack !== N'(1 << exp)) begin
                fails++; $display("FAIL rr_ack[%0d]: ack=%b required %b", n, ack, N'(1 << exp));
            end
            modelPtr = (exp + 1) % N;
            if (n == 4) req = '0;
            else req[exp] = 1'b0;
            tick;
            if (n < 4) begin
                addrArr[exp] = AW'($urandom);
                lenArr[exp]  = LW'($urandom_range(1, 255));
                req[exp] = 1'b1;
                tick;
            end
        end
        tick;
        tests++;
        if ({busy, grant} !== 5'b0) begin
            fails++; $display("FAIL rr_idle: busy=%b grant=%b required 0", busy, grant);
        end
    endtask

    task automatic test_zero_length;
        logic [AW-1:0] a;
        a = AW'($urandom);
        addrArr[2] = a; lenArr[2] = '0; req = 4'b0100;
        tick;
        tests++;
        if ({ack, grant, dma_enable, busy, dma_address, dma_len} !== {4'b0100, 4'b0100, 1'b0, 1'b1, a, 8'd0}) begin
            fails++;
            $display("FAIL zero_len_ack: ack=%b g=%b en=%b busy=%b addr=%h len=%h required 0100 0100 0 1 %h 00",
                     ack, grant, dma_enable, busy, dma_address, dma_len, a);
        end
        req = '0;
        tick;
        tests++;
        if ({ack, busy, dma_enable} !== 6'b0) begin
            fails++; $display("FAIL zero_len_idle: ack=%b busy=%b en=%b required 0", ack, busy, dma_enable);
        end
        modelPtr = 3;
    endtask

    task automatic test_spurious;
        logic [AW-1:0] held;
        held = dma_address;
        req = '0; dma_op_done = 1'b1;
        tick;
        dma_op_done = 1'b0;
        tests++;
        if ({busy, grant, ack, dma_enable, dma_address} !== {10'b0, held}) begin
            fails++;
            $display("FAIL spurious_done: busy=%b g=%b ack=%b en=%b addr=%h required 0 0 0 0 %h",
                     busy, grant, ack, dma_enable, dma_address, held);
        end
        lenArr[0] = LW'($urandom_range(1, 150));
        req = 4'b0001;
        tick;
        tests++;
        if ({dma_enable, grant} !== 5'b10001) begin
            fails++; $display("FAIL withdraw_strobe: en=%b g=%b required 1 0001", dma_enable, grant);
        end
        dma_op_done = 1'b1;
        tick;
        dma_op_done = 1'b0;
        req = '0;
        tick;
        tests++;
        if ({ack, busy, grant} !== {4'b0000, 1'b1, 4'b0001}) begin
            fails++; $display("FAIL done_in_issue_ignored: ack=%b busy=%b g=%b required 0000 1 0001", ack, busy, grant);
        end
        dma_op_done = 1'b1;
        tick;
        dma_op_done = 1'b0;
        tests++;
        if (ack !== 4'b0001) begin
            fails++; $display("FAIL withdraw_ack: ack=%b required 0001", ack);
        end
        tick;
        modelPtr = 1;
    endtask

    task automatic test_random;
        logic [N-1:0]  r;
        int            w, d;
        logic [AW-1:0] eA;
        logic [LW-1:0] eL;
        for (int it = 0; it < 40; it++) begin
            randomizeClients(1);
            r = N'($urandom_range(1, (1 << N) - 1));
            req = r;
            w = pickModel(r, modelPtr);
            eA = addrArr[w]; eL = lenArr[w];
            tick;
            tests++;
            if (grant !== N'(1 << w)) begin
                fails++; $display("FAIL rand_grant[%0d]: g=%b required %b (req %b)", it, grant, N'(1 << w), r);
            end
            if (eL != '0) begin
                tests++;
                if ({dma_enable, dma_address, dma_len} !== {1'b1, eA, eL}) begin
                    fails++;
                    $display("FAIL rand_strobe[%0d]: en=%b addr=%h len=%h required 1 %h %h", it, dma_enable, dma_address, dma_len, eA, eL);
                end
                randomizeClients(1);
                req = N'($urandom);
                d = $urandom_range(0, 4);
                tick;
                repeat (d) tick;
                tests++;
                if ({ack, dma_enable, dma_address, dma_len, busy} !== {4'b0, 1'b0, eA, eL, 1'b1}) begin
                    fails++;
                    $display("FAIL rand_wait[%0d]: ack=%b en=%b addr=%h len=%h busy=%b required 0 0 %h %h 1",
                             it, ack, dma_enable, dma_address, dma_len, busy, eA, eL);
                end
                dma_op_done = 1'b1;
                tick;
                dma_op_done = 1'b0;
            end
            tests++;
            if ({ack, grant, err, busy, dma_enable, dma_address, dma_len} !== {N'(1 << w), N'(1 << w), 4'b0, 1'b1, 1'b0, eA, eL}) begin
                fails++;
                $display("FAIL rand_ack[%0d]: ack=%b g=%b err=%b busy=%b en=%b addr=%h len=%h required client %0d addr %h len %h",
                         it, ack, grant, err, busy, dma_enable, dma_address, dma_len, w, eA, eL);
            end
            req = '0;
            tick;
            tests++;
            if ({busy, grant, ack} !== 9'b0) begin
                fails++; $display("FAIL rand_idle[%0d]: busy=%b g=%b ack=%b required 0", it, busy, grant, ack);
            end
            modelPtr = (w + 1) % N;
        end
    endtask

    task automatic test_timeout;
        bit bad;
        lenArr[3] = LW'($urandom_range(1, 150));
        req = 4'b1000;
        tick;
        tick;
        bad = 1'b0;
`ifdef CNN_DMA_ARB_TIMEOUT_EN
        for (int k = 1; k < TO; k++) begin
            tick;
            if (ack !== '0 || err !== '0 || busy !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++; $display("FAIL timeout_early: ack/err seen before %0d WAIT cycles (got %b) required 0", TO, bad);
        end
        tick;
        tests++;
        if ({ack, err} !== {4'b1000, 4'b1000}) begin
            fails++; $display("FAIL timeout_ack: ack=%b err=%b required 1000 1000", ack, err);
        end
`else
        for (int k = 0; k < 40; k++) begin
            tick;
            if (busy !== 1'b1 || err !== '0 || ack !== '0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++; $display("FAIL no_timeout_hold: got early release (%b) required busy 1 err 0", bad);
        end
        dma_op_done = 1'b1;
        tick;
        dma_op_done = 1'b0;
        tests++;
        if ({ack, err} !== {4'b1000, 4'b0000}) begin
            fails++; $display("FAIL no_timeout_ack: ack=%b err=%b required 1000 0000", ack, err);
        end
`endif
        req = '0;
        tick;
        tests++;
        if ({busy, err, ack} !== 9'b0) begin
            fails++; $display("FAIL timeout_idle: busy=%b err=%b ack=%b required 0", busy, err, ack);
        end
        modelPtr = 0;
    endtask

    task automatic test_reset_mid;
        bit sawAck;
        lenArr[2] = LW'($urandom_range(1, 150));
        req = 4'b0100;
        tick;
        tick;
        reset = 1'b1;
        dma_op_done = 1'b1;
        #1;
        tests++;
        if ({grant, ack, err, dma_enable, dma_address, dma_len, busy} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: g=%b a=%b e=%b en=%b addr=%h len=%h busy=%b required all 0",
                     grant, ack, err, dma_enable, dma_address, dma_len, busy);
        end
        req = '0;
        tick;
        reset = 1'b0;
        sawAck = 1'b0;
        tick;
        if (ack !== '0 || busy !== 1'b0) sawAck = 1'b1;
        dma_op_done = 1'b0;
        tick;
        if (ack !== '0 || busy !== 1'b0) sawAck = 1'b1;
        tests++;
        if (sawAck) begin
            fails++; $display("FAIL reset_mid_noack: got ack/busy after reset (%b) required none", sawAck);
        end
        modelPtr = 0;
        randomizeClients(0);
        req = '1;
        tick;
        tests++;
        if (grant !== N'(1 << pickModel(4'b1111, modelPtr))) begin
            fails++; $display("FAIL reset_mid_restart: g=%b required 0001", grant);
        end
        tick;
        dma_op_done = 1'b1;
        tick;
        dma_op_done = 1'b0;
        req = '0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = '0; dma_op_done = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_zero_length;
        test_spurious;
        test_random;
        test_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
